// File: rtl/period_meter_pkg.sv
// Shared types and default parameters for the period meter.
package period_meter_pkg;

  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_SYNC_STAGES = 2;
  localparam logic [31:0] DEF_TIMEOUT_CYC = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } pm_state_e;

endpackage

// File: rtl/period_meter_sync_rise_detect.sv
// Synchronizes an asynchronous input into the PCLK domain and flags its
// rising edges. The edge flag follows the input edge by SYNC_STAGES+1 PCLK
// edges (as seen by logic sampling it). SYNC_STAGES must be at least 2.
module sync_rise_detect
  import period_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic async_in,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  // Synchronizer chain followed by one history flop for edge detection.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign rise = r_sync[SYNC_STAGES-1] & ~r_hist;

endmodule

// File: rtl/period_meter.sv
// Measures the period of a slow asynchronous signal in PCLK cycles and
// presents each result on a valid/ready port with sticky status flags.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | disabled, count held at 0
// ST_ARM     | waiting for the first rising edge (it yields no result)
// ST_MEASURE | counting; each rising edge captures count and restarts at 1
module period_meter
  import period_meter_pkg::*;
#(
  parameter int unsigned      CNT_W       = DEF_CNT_W,
  parameter int unsigned      SYNC_STAGES = DEF_SYNC_STAGES,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(DEF_TIMEOUT_CYC)
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             status_clr,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic             timeout,
  output logic             overrun,
  output logic             busy
);

  pm_state_e        r_state;
  pm_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;
  logic             w_rise;
  logic             w_capture;
  logic             w_timeout_set;
  logic             w_overrun_set;

  sync_rise_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rise (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .async_in (sig_in),
    .rise     (w_rise)
  );

  // State and period counter registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Next-state and counter logic; disabling wins over edges and timeout,
  // and an edge landing on the timeout count is captured, not timed out.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_capture     = 1'b0;
    w_timeout_set = 1'b0;
    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_ARM;
          w_count_nxt = '0;
        end
        ST_ARM: begin
          if (w_rise) begin
            w_state_nxt = ST_MEASURE;
            w_count_nxt = CNT_W'(1);
          end
        end
        ST_MEASURE: begin
          if (w_rise) begin
            w_capture   = 1'b1;
            w_count_nxt = CNT_W'(1);
          end else if (r_count == TIMEOUT_CYC) begin
            w_timeout_set = 1'b1;
            w_count_nxt   = '0;
            w_state_nxt   = ST_ARM;
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  assign w_overrun_set = w_capture & meas_valid & ~meas_ready;

  // Result register with valid/ready handshake; a capture against a stalled
  // consumer is dropped so the held value stays stable.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      meas_valid  <= 1'b0;
      meas_period <= '0;
    end else begin
      if (w_capture) begin
        if (!meas_valid || meas_ready) begin
          meas_period <= r_count;
          meas_valid  <= 1'b1;
        end
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

  // Sticky status flags; a set event beats a simultaneous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      timeout <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (w_timeout_set)   timeout <= 1'b1;
      else if (status_clr) timeout <= 1'b0;
      if (w_overrun_set)   overrun <= 1'b1;
      else if (status_clr) overrun <= 1'b0;
    end
  end

  assign busy = (r_state == ST_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter with TIMEOUT_CYC=100.
// Loop convention: iteration c drives inputs, then waits for the next PCLK
// edge plus 1ns and samples. A rise driven in iteration c is captured by the
// FSM on the edge of iteration c+2.
module tb_period_meter;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        sig_in;
  logic        enable;
  logic        status_clr;
  logic        meas_ready;
  logic        meas_valid;
  logic [31:0] meas_period;
  logic        timeout;
  logic        overrun;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  period_meter #(
    .CNT_W       (32),
    .SYNC_STAGES (2),
    .TIMEOUT_CYC (32'd100)
  ) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .sig_in      (sig_in),
    .enable      (enable),
    .status_clr  (status_clr),
    .meas_ready  (meas_ready),
    .meas_valid  (meas_valid),
    .meas_period (meas_period),
    .timeout     (timeout),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Disable, flush synchronizer, drain result, clear flags, then arm.
  task automatic prep();
    enable     = 1'b0;
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    status_clr = 1'b0;
    repeat (5) tick();
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    enable     = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    int pulses;
    PRESETn    = 1'b1;
    enable     = 1'b0;
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    status_clr = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL por_valid got=%0b exp=0", meas_valid); end
    checks++; if (meas_period !== 32'd0) begin failures++; $display("FAIL por_period got=%0d exp=0", meas_period); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL por_busy got=%0b exp=0", busy); end
    checks++; if ({timeout, overrun} !== 2'b00) begin failures++; $display("FAIL por_flags got=%b exp=00", {timeout, overrun}); end
    repeat (3) tick();
    PRESETn = 1'b1;
    tick();

    prep();
    meas_ready = 1'b0;
    for (int c = 0; c <= 43; c++) begin
      sig_in = ((c % 20) < 10);
      tick();
      if (c == 22) begin
        checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL rst_pre_result valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
      end
    end
    checks++; if (busy !== 1'b1 || overrun !== 1'b1) begin failures++; $display("FAIL rst_pre_state busy=%0b overrun=%0b exp 1/1", busy, overrun); end
    #2 PRESETn = 1'b0;
    #1;
    checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%0b exp=0", meas_valid); end
    checks++; if (meas_period !== 32'd0) begin failures++; $display("FAIL rst_mid_period got=%0d exp=0", meas_period); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    checks++; if ({timeout, overrun} !== 2'b00) begin failures++; $display("FAIL rst_mid_flags got=%b exp=00", {timeout, overrun}); end
    sig_in     = 1'b0;
    enable     = 1'b1;
    meas_ready = 1'b1;
    #3 PRESETn = 1'b1;
    pulses = 0;
    for (int c = 0; c <= 30; c++) begin
      sig_in = ((c >= 5 && c < 15) || (c >= 25 && c < 35));
      tick();
      if (meas_valid) pulses++;
      if (c == 27) begin
        checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL rst_after_result valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
      end
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL rst_after_pulses got=%0d exp=1", pulses); end
  endtask

  task automatic test_nominal(input int p);
    int pulses;
    int hi;
    bit exp_v;
    prep();
    hi = p / 2;
    pulses = 0;
    for (int c = 0; c <= 5 * p + 2; c++) begin
      sig_in = ((c % p) < hi);
      tick();
      exp_v = (c >= p + 2) && (((c - 2) % p) == 0);
      checks++;
      if (meas_valid !== exp_v) begin
        failures++;
        $display("FAIL nominal_p%0d_valid c=%0d got=%0b exp=%0b", p, c, meas_valid, exp_v);
      end
      if (meas_valid) begin
        pulses++;
        checks++;
        if (meas_period !== 32'(p)) begin
          failures++;
          $display("FAIL nominal_p%0d_period c=%0d got=%0d exp=%0d", p, c, meas_period, p);
        end
      end
    end
    checks++; if (pulses != 5) begin failures++; $display("FAIL nominal_p%0d_pulses got=%0d exp=5", p, pulses); end
  endtask

  task automatic test_backpressure();
    prep();
    meas_ready = 1'b0;
    for (int c = 0; c <= 69; c++) begin
      sig_in = ((c % 20) < 10);
      tick();
      if (c == 22) begin
        checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL bp_first valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
      end
      if (c == 41) begin
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL bp_overrun_early got=%0b exp=0", overrun); end
      end
      if (c == 42) begin
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_overrun_set got=%0b exp=1", overrun); end
      end
    end
    checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL bp_hold valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
    sig_in     = 1'b0;
    meas_ready = 1'b1;
    tick();
    checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL bp_accept valid=%0b exp=0", meas_valid); end
    checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL bp_sticky got=%0b exp=1", overrun); end
    meas_ready = 1'b0;
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    checks++; if (overrun !== 1'b0 || timeout !== 1'b0) begin failures++; $display("FAIL bp_clear overrun=%0b timeout=%0b exp 0/0", overrun, timeout); end
  endtask

  task automatic test_back_to_back();
    prep();
    meas_ready = 1'b0;
    for (int c = 0; c <= 50; c++) begin
      sig_in     = ((c < 5) || (c >= 20 && c < 25) || (c >= 45 && c < 50));
      meas_ready = (c == 47);
      tick();
      if (c == 22) begin
        checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL b2b_first valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
      end
      if (c == 47) begin
        checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd25) begin failures++; $display("FAIL b2b_swap valid=%0b period=%0d exp 1/25", meas_valid, meas_period); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
      end
      if (c == 48) begin
        checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd25) begin failures++; $display("FAIL b2b_hold valid=%0b period=%0d exp 1/25", meas_valid, meas_period); end
      end
    end
  endtask

  task automatic test_timeout();
    int pulses;
    prep();
    pulses = 0;
    for (int c = 0; c <= 263; c++) begin
      sig_in = ((c < 5) || (c >= 20 && c < 25) || (c >= 130 && c < 135) ||
                (c >= 160 && c < 165) || (c >= 260 && c < 265));
      status_clr = (c == 200);
      tick();
      if (c >= 123 && c <= 261 && meas_valid) pulses++;
      case (c)
        22: begin
          checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL to_first valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
        end
        121: begin
          checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_before timeout=%0b busy=%0b exp 0/1", timeout, busy); end
        end
        122: begin
          checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL to_fire timeout=%0b busy=%0b exp 1/0", timeout, busy); end
        end
        162: begin
          checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd30) begin failures++; $display("FAIL to_rearm_result valid=%0b period=%0d exp 1/30", meas_valid, meas_period); end
        end
        199: begin
          checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b exp=1", timeout); end
        end
        201: begin
          checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_clear got=%0b exp=0", timeout); end
        end
        262: begin
          checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd100) begin failures++; $display("FAIL to_edge_at_limit valid=%0b period=%0d exp 1/100", meas_valid, meas_period); end
          checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL to_edge_no_timeout timeout=%0b busy=%0b exp 0/1", timeout, busy); end
        end
        263: begin
          checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_after_limit got=%0b exp=0", timeout); end
        end
        default: ;
      endcase
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL to_single_result got=%0d exp=1", pulses); end
  endtask

  task automatic test_enable_drop();
    int pulses;
    prep();
    meas_ready = 1'b0;
    pulses = 0;
    for (int c = 0; c <= 84; c++) begin
      sig_in     = ((c % 20) < 10);
      enable     = !(c >= 30 && c < 52);
      meas_ready = (c == 50);
      tick();
      if (c >= 51 && c <= 81 && meas_valid) pulses++;
      case (c)
        22: begin
          checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL en_first valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
        end
        29: begin
          checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_busy_before got=%0b exp=1", busy); end
        end
        30: begin
          checks++; if (busy !== 1'b0 || meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL en_drop busy=%0b valid=%0b period=%0d exp 0/1/20", busy, meas_valid, meas_period); end
        end
        45: begin
          checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20 || overrun !== 1'b0) begin failures++; $display("FAIL en_idle_hold valid=%0b period=%0d overrun=%0b exp 1/20/0", meas_valid, meas_period, overrun); end
        end
        50: begin
          checks++; if (meas_valid !== 1'b0) begin failures++; $display("FAIL en_drain got=%0b exp=0", meas_valid); end
        end
        52: begin
          checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en_rearm_busy got=%0b exp=0", busy); end
        end
        62: begin
          checks++; if (busy !== 1'b1) begin failures++; $display("FAIL en_measure_busy got=%0b exp=1", busy); end
        end
        82: begin
          checks++; if (meas_valid !== 1'b1 || meas_period !== 32'd20) begin failures++; $display("FAIL en_fresh_result valid=%0b period=%0d exp 1/20", meas_valid, meas_period); end
        end
        default: ;
      endcase
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL en_no_early_result got=%0d exp=0", pulses); end
  endtask

  initial begin
    test_reset();
    test_nominal(20);
    test_nominal(2);
    test_nominal(3);
    test_nominal(64);
    test_backpressure();
    test_back_to_back();
    test_timeout();
    test_enable_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of a slow, asynchronous clock-like signal, such as the prescaled output clock, in PCLK cycles.
- It performs the inverse job of the prescaler and lets firmware/self-test confirm the divided rate.
- Sits on the PCLK domain and presents each measured period on a valid/ready result port with sticky status flags.

Parameters:
- CNT_W, 32, width of period counter and result.
- SYNC_STAGES, 2, synchronizer flops on sig_in (min 2).
- TIMEOUT_CYC, 32'hFFFF_FFFF, max PCLK cycles between rising edges before timeout (must be ≤ 2^CNT_W-1, ≥ 2).

Ports:
- PCLK  in  1  system clock; all logic on posedge.
- PRESETn  in  1  asynchronous active-low reset.
- sig_in  in  1  asynchronous signal to measure.
- enable  in  1  level; 1 = measure, 0 = idle.
- status_clr  in  1  single-cycle pulse clearing timeout and overrun.
- meas_ready  in  1  consumer accepts result.
- meas_valid  out  1  result available.
- meas_period  out  CNT_W  PCLK cycles between consecutive rising edges.
- timeout  out  1  sticky: no edge within TIMEOUT_CYC.
- overrun  out  1  sticky: result dropped while meas_valid held.
- busy  out  1  state is MEASURE.

Behaviour:
- Reset (PRESETn=0, async): sync chain=0, edge history=0, state=IDLE, count=0, meas_valid=0, meas_period=0, timeout=0, overrun=0, busy=0. Reset mid-operation discards any partial count.
- Sync/edge detect:
  - sig_in passes through SYNC_STAGES flops, then one history flop.
  - rise=sync_out & ~hist.
  - Latency from sig_in edge to rise is SYNC_STAGES+1 PCLK edges.
  - Falling edges are ignored.
- FSM states: IDLE, ARM, MEASURE.
  - IDLE: count held 0. enable=1 → ARM next cycle.
  - ARM: wait for rise. On rise → MEASURE, count<=1. The first edge never produces a result.
  - MEASURE: count increments each cycle.
    - On rise: capture count as result, count<=1, remain MEASURE.
    - Timing: edges P cycles apart give result P (count=k at k cycles after the edge).
  - Timeout: in MEASURE, if count==TIMEOUT_CYC and no rise → timeout<=1, count<=0, state → ARM.
  - Rise on the same cycle as count==TIMEOUT_CYC: capture wins (result=TIMEOUT_CYC), no timeout.
  - enable=0 in any state → IDLE next cycle, count<=0, partial measurement discarded. This has priority over rise/timeout.
- Result handshake:
  - Capture with meas_valid=0: meas_period<=count, meas_valid<=1.
  - meas_valid=1 & meas_ready=1 & no capture: meas_valid<=0.
  - Capture with meas_valid=1 & meas_ready=1: load new value, meas_valid stays 1.
  - Capture with meas_valid=1 & meas_ready=0: new value dropped, overrun<=1, meas_period unchanged.
  - meas_period stable while meas_valid=1 & meas_ready=0.
  - meas_valid/meas_period unaffected by enable deassertion; a held result is still deliverable.
- Flags:
  - timeout and overrun are sticky until status_clr.
  - If status_clr coincides with a new set event, the set wins.
- Width: count never exceeds TIMEOUT_CYC, so there is no wrap.
- busy=1 iff state==MEASURE.

Decomposition:
- Shared package period_meter_pkg holds:
  - state enum {IDLE, ARM, MEASURE};
  - default CNT_W/SYNC_STAGES/TIMEOUT_CYC constants.
- Sub-module sync_rise_detect (parameter SYNC_STAGES): PCLK, PRESETn, async_in → rise. It is reusable for other async inputs.
- FSM, counter, result register and flags live in period_meter.

Test Plan:
- Reset: assert PRESETn=0 mid-MEASURE with sig_in toggling → all outputs 0 immediately (async), state IDLE. After release with enable=1, the first result appears only after the second rising edge.
- Nominal: TIMEOUT_CYC=1000, sig_in square wave with 20-PCLK period, meas_ready=1 → first edge gives no result, then meas_period=20 with a one-cycle meas_valid pulse per period. Also run periods 2, 3 and 64.
- Backpressure: period 20, meas_ready=0 for 70 cycles → meas_period holds first value 20 and overrun=1. Raise ready → accepted. status_clr → overrun=0.
- Simultaneous capture and ready: ready asserted exactly on the capture cycle of the next value → meas_valid stays 1 with new value, overrun stays 0.
- Timeout:
  - TIMEOUT_CYC=100, sig_in stuck after an edge → timeout=1 exactly 100 cycles after the captured edge, busy=0 (ARM).
  - Next edges 30 apart → single result 30, timeout still 1.
  - Edge exactly at count=100 → result 100, no timeout.
- Enable drop: deassert enable 10 cycles into a 20-cycle period → no result, IDLE, busy=0, pending valid result retained. Re-enable → ARM, first result only after two fresh edges.
